iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Multi-cycle execute unit; the consumer end of the decoder's `t_alu_operation` encoding.
- Accepts one decoded ALU request through a valid/ready handshake and computes add, sub and logic ops in one step.
- Performs shifts iteratively, SHIFT_STEP bits per cycle, to avoid a full barrel shifter.
- Returns the result, destination register tag and zero flag (used for BRANCH_NE resolution) through a second valid/ready handshake to writeback/branch logic.

Parameters:
- SHIFT_STEP, 1: bits shifted per cycle in the shift state. Legal values 1, 2, 4, 8, 16.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  t_alu_operation  operation
- req_a  in  32 (t_data)  operand A
- req_b  in  32 (t_data)  operand B; bits [4:0] give the shift amount for shifts
- req_rd  in  5 (t_register_index)  destination tag, passed through unchanged
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_result  out  32 (t_data)  result
- rsp_rd  out  5 (t_register_index)  tag of the result
- rsp_zero  out  1  rsp_result == 0
- rsp_illegal  out  1  request op was ALU_OP_INVALID
- busy  out  1  state != IDLE

Behaviour:
- Interface reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_rd=0; rsp_zero=1; rsp_illegal=0; busy=0; shift counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready=1.
  - Accept occurs on a cycle with req_valid && req_ready; the req_* inputs are sampled only then.
  - Non-shift op or shamt==0: result latched, next state DONE.
  - Shift op with shamt!=0: operand and counter=shamt latched, next state SHIFT.
- SHIFT:
  - req_ready=0.
  - Each cycle shifts by min(SHIFT_STEP, counter) and decrements counter by the same amount.
  - When counter reaches 0, next state DONE.
- DONE:
  - rsp_valid=1; req_ready=0.
  - All rsp_* outputs stay stable until rsp_valid && rsp_ready, then next state IDLE.
  - No same-cycle bypass: a new request can be accepted at earliest the cycle after the response handshake.
- Latency (accept edge to rsp_valid): non-shift ops and shamt==0 take 1 cycle; shifts take 1 + ceil(shamt/SHIFT_STEP) cycles.
- Arithmetic:
  - ADD and SUB wrap modulo 2^32; no overflow flag.
  - XOR, OR and AND are bitwise.
  - SHIFT_LEFT fills with zeros; SHIFT_RIGHT_LOGIC fills with zeros; SHIFT_RIGHT_ARITH replicates bit 31.
  - Only req_b[4:0] is used for shifts; upper bits are ignored.
- ALU_OP_INVALID (or any unlisted encoding): result 0, rsp_illegal=1, latency 1.
- rsp_zero is derived from the registered result.
- Input changes while busy are ignored; req_valid held high while busy is not lost and is accepted on the next IDLE cycle.
- Reset mid-operation: asynchronous return to reset values; the in-flight request is discarded with no response. Normal operation resumes on the first edge after rst_n rises.

Decomposition:
- Add to the definitions package:
  - t_alu_state enum {ALU_STATE_IDLE, ALU_STATE_SHIFT, ALU_STATE_DONE}
  - t_shift_amount (logic [4:0])
  - Packed struct t_alu_request {op, a, b, rd}, so the decode stage can register one bundle.
- One natural combinational sub-module: alu_shift_step (inputs: value, step amount, direction/arith select; output: shifted value). It is instantiated once inside SHIFT.

Test Plan:
- ADD a=0xFFFFFFFF b=0x1 rd=5 → rsp_valid one cycle after accept; result 0x00000000, rsp_zero=1, rsp_rd=5.
- SUB a=3 b=5 → result 0xFFFFFFFE, rsp_zero=0, latency 1.
- SHIFT_RIGHT_ARITH a=0x80000000 b=0x1F, SHIFT_STEP=1 → result 0xFFFFFFFF after 32 cycles; req_ready=0 and busy=1 throughout. Repeat with SHIFT_LEFT a=0x1 b=0x24 → result 0x10, latency 5.
- Backpressure: rsp_ready low for 10 cycles with a new req_valid pending → rsp_* stable, no second accept. Raise rsp_ready → IDLE next cycle, then the pending request is accepted.
- Drop rst_n mid-SHIFT → outputs return to reset values immediately, no response. Next ADD 2+2 after release → result 4.
- ALU_OP_INVALID → rsp_illegal=1, result 0, rsp_zero=1; the following valid ADD returns rsp_illegal=0.

Source files
------------

// File: rtl/iterative_alu_pkg.sv
// -----------------------------------------------------------------------------
// iterative_alu_pkg
// Shared definitions for the iterative ALU: data and register-index types, the
// decoded ALU operation encoding, the ALU FSM state encoding and the request
// bundle a decode stage can register as a single flop group.
// -----------------------------------------------------------------------------
package iterative_alu_pkg;

  typedef logic [31:0] t_data;
  typedef logic [4:0]  t_register_index;
  typedef logic [4:0]  t_shift_amount;

  // Encodings not listed here are treated exactly like ALU_OP_INVALID.
  typedef enum logic [3:0] {
    ALU_OP_ADD               = 4'd0,
    ALU_OP_SUB               = 4'd1,
    ALU_OP_XOR               = 4'd2,
    ALU_OP_OR                = 4'd3,
    ALU_OP_AND               = 4'd4,
    ALU_OP_SHIFT_LEFT        = 4'd5,
    ALU_OP_SHIFT_RIGHT_LOGIC = 4'd6,
    ALU_OP_SHIFT_RIGHT_ARITH = 4'd7,
    ALU_OP_INVALID           = 4'd15
  } t_alu_operation;

  typedef enum logic [1:0] {
    ALU_STATE_IDLE  = 2'd0,
    ALU_STATE_SHIFT = 2'd1,
    ALU_STATE_DONE  = 2'd2
  } t_alu_state;

  typedef struct packed {
    t_alu_operation  op;
    t_data           a;
    t_data           b;
    t_register_index rd;
  } t_alu_request;

  function automatic logic is_shift_op(input t_alu_operation op);
    return (op == ALU_OP_SHIFT_LEFT) ||
           (op == ALU_OP_SHIFT_RIGHT_LOGIC) ||
           (op == ALU_OP_SHIFT_RIGHT_ARITH);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// -----------------------------------------------------------------------------
// alu_shift_step
// One iteration of the iterative shifter. Shifts 'value' by 'amount' bits,
// where 'amount' is at most MAX_STEP. Only the constant shifts 1..MAX_STEP are
// built and selected by a mux, so no full 32-bit barrel shifter is inferred.
//
// Ports:
//   value  in   operand being shifted
//   amount in   bits to shift this cycle (0..MAX_STEP; 0 passes value through)
//   left   in   1 = shift left (zero fill), 0 = shift right
//   arith  in   right shifts only: 1 = replicate bit 31, 0 = zero fill
//   result out  shifted value
// -----------------------------------------------------------------------------
module alu_shift_step
  import iterative_alu_pkg::*;
#(
  parameter int MAX_STEP = 1
) (
  input  t_data         value,
  input  t_shift_amount amount,
  input  logic          left,
  input  logic          arith,
  output t_data         result
);

  always_comb begin
    result = value;
    for (int k = 1; k <= MAX_STEP; k++) begin
      if (amount == t_shift_amount'(k)) begin
        if (left) begin
          result = value << k;
        end else if (arith) begin
          result = t_data'($signed(value) >>> k);
        end else begin
          result = value >> k;
        end
      end
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
// Multi-cycle execute unit. Takes one decoded ALU request per handshake,
// computes add/sub/logic ops in a single step and shifts iteratively,
// SHIFT_STEP bits per cycle, then presents result, destination tag, zero flag
// and illegal flag on a response handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer holds its payload stable while valid is high and not yet accepted.
// req_* inputs are sampled only on the accepting edge; rsp_* outputs are held
// stable while rsp_valid is high until the consumer takes them.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_op/a/b/rd        operation, operands (b[4:0] = shift amount), dest tag
//   rsp_valid/rsp_ready  response handshake
//   rsp_result/rd        result and its destination tag
//   rsp_zero             rsp_result == 0
//   rsp_illegal          request op was invalid/unlisted
//   busy                 unit is not idle
//   dbg_state            current FSM state
// -----------------------------------------------------------------------------
module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  t_alu_operation  req_op,
  input  t_data           req_a,
  input  t_data           req_b,
  input  t_register_index req_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output t_data           rsp_result,
  output t_register_index rsp_rd,
  output logic            rsp_zero,
  output logic            rsp_illegal,
  output logic            busy,
  output t_alu_state      dbg_state
);

  localparam t_shift_amount STEP_AMT = t_shift_amount'(SHIFT_STEP);

  t_alu_state      state_q, state_d;
  t_shift_amount   count_q, count_d;
  t_data           work_q, work_d;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  t_data           result_q, result_d;
  t_register_index rd_q, rd_d;
  logic            illegal_q, illegal_d;

  t_alu_request    req;
  t_shift_amount   shamt;
  t_shift_amount   step_amt;
  t_shift_amount   count_next;
  t_data           shift_out;

  assign req   = '{op: req_op, a: req_a, b: req_b, rd: req_rd};
  assign shamt = req.b[4:0];

  // Never shift past the remaining count on the last iteration.
  assign step_amt   = (count_q < STEP_AMT) ? count_q : STEP_AMT;
  assign count_next = count_q - step_amt;

  alu_shift_step #(
    .MAX_STEP (SHIFT_STEP)
  ) u_shift_step (
    .value  (work_q),
    .amount (step_amt),
    .left   (left_q),
    .arith  (arith_q),
    .result (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALU_STATE_IDLE;
      count_q   <= '0;
      work_q    <= '0;
      left_q    <= 1'b0;
      arith_q   <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      work_q    <= work_d;
      left_q    <= left_d;
      arith_q   <= arith_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    work_d    = work_q;
    left_d    = left_q;
    arith_d   = arith_q;
    result_d  = result_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      ALU_STATE_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rd_d      = req.rd;
          illegal_d = 1'b0;
          state_d   = ALU_STATE_DONE;
          case (req.op)
            ALU_OP_ADD: result_d = req.a + req.b;
            ALU_OP_SUB: result_d = req.a - req.b;
            ALU_OP_XOR: result_d = req.a ^ req.b;
            ALU_OP_OR:  result_d = req.a | req.b;
            ALU_OP_AND: result_d = req.a & req.b;
            ALU_OP_SHIFT_LEFT,
            ALU_OP_SHIFT_RIGHT_LOGIC,
            ALU_OP_SHIFT_RIGHT_ARITH: begin
              if (shamt == '0) begin
                result_d = req.a;
              end else begin
                work_d  = req.a;
                count_d = shamt;
                left_d  = (req.op == ALU_OP_SHIFT_LEFT);
                arith_d = (req.op == ALU_OP_SHIFT_RIGHT_ARITH);
                state_d = ALU_STATE_SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end

      ALU_STATE_SHIFT: begin
        work_d  = shift_out;
        count_d = count_next;
        if (count_next == '0) begin
          result_d = shift_out;
          state_d  = ALU_STATE_DONE;
        end
      end

      ALU_STATE_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ALU_STATE_IDLE;
        end
      end

      default: begin
        state_d = ALU_STATE_IDLE;
      end
    endcase
  end

  assign rsp_result  = result_q;
  assign rsp_rd      = rd_q;
  assign rsp_illegal = illegal_q;
  assign rsp_zero    = (result_q == '0);
  assign busy        = (state_q != ALU_STATE_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;
  import iterative_alu_pkg::*;

  localparam int STEP = 1;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  t_alu_operation  req_op;
  t_data           req_a;
  t_data           req_b;
  t_register_index req_rd;
  logic            rsp_valid;
  logic            rsp_ready;
  t_data           rsp_result;
  t_register_index rsp_rd;
  logic            rsp_zero;
  logic            rsp_illegal;
  logic            busy;
  t_alu_state      dbg_state;

  int checks = 0;
  int errors = 0;

  iterative_alu #(.SHIFT_STEP(STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_rd      (rsp_rd),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Presents a request, waits for acceptance, then scrambles the inputs so a
  // design that samples them late is caught. Returns accept-to-valid latency
  // and how many in-flight cycles showed req_ready high or busy low.
  task automatic run_req(input t_alu_operation op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output int busy_bad);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    guard     = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = 32'hA5A5A5A5;
    req_b     = 32'hFFFFFFFF;
    req_rd    = 5'd31;
    lat       = 1;
    busy_bad  = 0;
    while (!rsp_valid && lat < 100) begin
      if (req_ready || !busy) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    t_alu_operation op;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [4:0]     rd;
    logic [31:0]    exp_result;
    logic           exp_illegal;
    int             exp_lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    int busy_bad;
    int seen;
    int stable_bad;

    vecs[0]  = '{ALU_OP_ADD,               32'hFFFFFFFF, 32'h00000001, 5'd5,  32'h00000000, 1'b0, 1};
    vecs[1]  = '{ALU_OP_SUB,               32'h00000003, 32'h00000005, 5'd1,  32'hFFFFFFFE, 1'b0, 1};
    vecs[2]  = '{ALU_OP_XOR,               32'hF0F0F0F0, 32'hFF00FF00, 5'd2,  32'h0FF00FF0, 1'b0, 1};
    vecs[3]  = '{ALU_OP_OR,                32'h12340000, 32'h00005678, 5'd3,  32'h12345678, 1'b0, 1};
    vecs[4]  = '{ALU_OP_AND,               32'hFFFF0000, 32'h0F0F0F0F, 5'd4,  32'h0F0F0000, 1'b0, 1};
    vecs[5]  = '{ALU_OP_SHIFT_RIGHT_ARITH, 32'h80000000, 32'h0000001F, 5'd6,  32'hFFFFFFFF, 1'b0, 32};
    vecs[6]  = '{ALU_OP_SHIFT_LEFT,        32'h00000001, 32'h00000024, 5'd7,  32'h00000010, 1'b0, 5};
    vecs[7]  = '{ALU_OP_SHIFT_RIGHT_LOGIC, 32'h80000000, 32'h00000021, 5'd8,  32'h40000000, 1'b0, 2};
    vecs[8]  = '{ALU_OP_SHIFT_LEFT,        32'hDEADBEEF, 32'h00000020, 5'd9,  32'hDEADBEEF, 1'b0, 1};
    vecs[9]  = '{ALU_OP_SHIFT_RIGHT_ARITH, 32'h7FFFFFFF, 32'h00000003, 5'd10, 32'h0FFFFFFF, 1'b0, 4};
    vecs[10] = '{ALU_OP_INVALID,           32'h00000005, 32'h00000006, 5'd11, 32'h00000000, 1'b1, 1};
    vecs[11] = '{ALU_OP_ADD,               32'h00000001, 32'h00000001, 5'd12, 32'h00000002, 1'b0, 1};
    vecs[12] = '{t_alu_operation'(4'd9),   32'h00000007, 32'h00000008, 5'd13, 32'h00000000, 1'b1, 1};
    vecs[13] = '{ALU_OP_ADD,               32'h7FFFFFFF, 32'h00000001, 5'd14, 32'h80000000, 1'b0, 1};

    // -------------------------------------------------------------- reset
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = ALU_OP_ADD;
    req_a     = '0;
    req_b     = '0;
    req_rd    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready",   32'(req_ready),   32'd1);
    check("reset_rsp_valid",   32'(rsp_valid),   32'd0);
    check("reset_rsp_result",  rsp_result,       32'd0);
    check("reset_rsp_rd",      32'(rsp_rd),      32'd0);
    check("reset_rsp_zero",    32'(rsp_zero),    32'd1);
    check("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("reset_busy",        32'(busy),        32'd0);
    check("reset_state",       32'(dbg_state),   32'(ALU_STATE_IDLE));
    rst_n = 1'b1;

    // -------------------------------------------------------------- table
    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, busy_bad);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_result", i),  rsp_result, vecs[i].exp_result);
      check($sformatf("v%0d_zero", i),    32'(rsp_zero), 32'(vecs[i].exp_result == 32'd0));
      check($sformatf("v%0d_rd", i),      32'(rsp_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_illegal", i), 32'(rsp_illegal), 32'(vecs[i].exp_illegal));
      check($sformatf("v%0d_busy_while_shifting", i), 32'(busy_bad), 32'd0);
      take_rsp();
      check($sformatf("v%0d_idle_after_rsp", i), 32'(busy), 32'd0);
    end

    // -------------------------------------------------------------- backpressure
    run_req(ALU_OP_ADD, 32'd10, 32'd20, 5'd7, lat, busy_bad);
    check("bp_first_result", rsp_result, 32'd30);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = ALU_OP_SUB;
    req_a     = 32'd9;
    req_b     = 32'd4;
    req_rd    = 5'd3;
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_result !== 32'd30 || rsp_rd !== 5'd7 ||
          rsp_zero !== 1'b0 || rsp_illegal !== 1'b0 || dbg_state !== ALU_STATE_DONE)
        stable_bad++;
    end
    check("bp_rsp_stable", 32'(stable_bad), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_idle_after_handshake", 32'(dbg_state), 32'(ALU_STATE_IDLE));
    check("bp_ready_after_handshake", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_pending_accepted", 32'(rsp_valid), 32'd1);
    check("bp_pending_result", rsp_result, 32'd5);
    check("bp_pending_rd", 32'(rsp_rd), 32'd3);
    take_rsp();

    // -------------------------------------------------------------- reset mid-shift
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = ALU_OP_SHIFT_RIGHT_ARITH;
    req_a     = 32'h80000000;
    req_b     = 32'h0000001F;
    req_rd    = 5'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_in_shift", 32'(dbg_state), 32'(ALU_STATE_SHIFT));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_state",     32'(dbg_state),   32'(ALU_STATE_IDLE));
    check("rst_mid_busy",      32'(busy),        32'd0);
    check("rst_mid_req_ready", 32'(req_ready),   32'd1);
    check("rst_mid_rsp_valid", 32'(rsp_valid),   32'd0);
    check("rst_mid_result",    rsp_result,       32'd0);
    check("rst_mid_rd",        32'(rsp_rd),      32'd0);
    check("rst_mid_zero",      32'(rsp_zero),    32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_mid_no_response", 32'(seen), 32'd0);
    run_req(ALU_OP_ADD, 32'd2, 32'd2, 5'd4, lat, busy_bad);
    check("post_rst_add_latency", 32'(lat), 32'd1);
    check("post_rst_add_result", rsp_result, 32'd4);
    check("post_rst_add_rd", 32'(rsp_rd), 32'd4);
    take_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
